// File: rtl/seven_segment_capture_if.sv
// Snooped seven-segment display bus plus the decoded frame and status outputs of the capture monitor.
// The master drives the display lines and the slave is the capture block.
interface seven_segment_capture_if;
    logic [3:0]  controlLed;
    logic [6:0]  seg;
    logic        segDp;
    logic [15:0] digit;
    logic [3:0]  dp;
    logic        frameValid;
    logic        segErr;
    logic        anodeErr;
    logic        timeout;

    modport master (
        output controlLed, seg, segDp,
        input  digit, dp, frameValid, segErr, anodeErr, timeout
    );

    modport slave (
        input  controlLed, seg, segDp,
        output digit, dp, frameValid, segErr, anodeErr, timeout
    );
endinterface

// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed 4-digit seven-segment bus.
// It waits for each digit dwell to settle, decodes it to a hex nibble and assembles 16-bit frames.
module seven_segment_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 20
) (
    input logic                    clk,
    input logic                    rst,
    seven_segment_capture_if.slave bus
);
    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [11:0]      smp;
    logic [11:0]      prevSmp;
    logic             change;
    logic [1:0]       state;
    logic [CNT_W-1:0] settleCnt;
    logic [CNT_W-1:0] timeoutCnt;
    logic [3:0]       mask;
    logic [15:0]      shadow;
    logic [3:0]       dpSh;
    logic [15:0]      digitReg;
    logic [3:0]       dpReg;
    logic             frameValidReg;
    logic             segErrReg;
    logic             anodeErrReg;
    logic             timeoutReg;

    logic [3:0]       anode;
    logic [6:0]       segs;
    logic             dpBit;
    logic             anodeBlank;
    logic             anodeOk;
    logic [1:0]       digitIdx;
    logic             segValid;
    logic [3:0]       nibble;
    logic             evaluate;
    logic             validLatch;
    logic             segErrEv;
    logic             anodeErrEv;
    logic             timeoutFire;

    assign anode  = smp[11:8];
    assign segs   = smp[7:1];
    assign dpBit  = smp[0];
    assign change = (smp != prevSmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            smp     <= '0;
            prevSmp <= '0;
        end else begin
            smp     <= {bus.controlLed, bus.seg, bus.segDp};
            prevSmp <= smp;
        end
    end

    always_comb begin
        anodeBlank = (anode == 4'b1111);
        anodeOk    = 1'b1;
        digitIdx   = 2'd0;
        case (anode)
            4'b1110: digitIdx = 2'd0;
            4'b1101: digitIdx = 2'd1;
            4'b1011: digitIdx = 2'd2;
            4'b0111: digitIdx = 2'd3;
            default: anodeOk  = 1'b0;
        endcase
    end

    // Segment lines are active-low, ordered {a,b,c,d,e,f,g}.
    always_comb begin
        segValid = 1'b1;
        nibble   = 4'h0;
        case (segs)
            7'b0000001: nibble = 4'h0;
            7'b1001111: nibble = 4'h1;
            7'b0010010: nibble = 4'h2;
            7'b0000110: nibble = 4'h3;
            7'b1001100: nibble = 4'h4;
            7'b0100100: nibble = 4'h5;
            7'b0100000: nibble = 4'h6;
            7'b0001111: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0000100: nibble = 4'h9;
            7'b0001000: nibble = 4'hA;
            7'b1100000: nibble = 4'hB;
            7'b0110001: nibble = 4'hC;
            7'b1000010: nibble = 4'hD;
            7'b0110000: nibble = 4'hE;
            7'b0111000: nibble = 4'hF;
            default:    segValid = 1'b0;
        endcase
    end

    assign evaluate    = (state == S_SETTLE) && !change && (settleCnt == SETTLE_LAST);
    assign validLatch  = evaluate && anodeOk && segValid;
    assign segErrEv    = evaluate && anodeOk && !segValid;
    assign anodeErrEv  = evaluate && !anodeOk && !anodeBlank;
    assign timeoutFire = !validLatch && (timeoutCnt == TIMEOUT_LAST);

    // HOLD only leaves on a new change, so a long dwell produces a single evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT;
            settleCnt <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (change) begin
                        state     <= S_SETTLE;
                        settleCnt <= CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (change) begin
                        settleCnt <= CNT_W'(1);
                    end else begin
                        settleCnt <= settleCnt + CNT_W'(1);
                        if (settleCnt == SETTLE_LAST) begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (change) begin
                        state     <= S_SETTLE;
                        settleCnt <= CNT_W'(1);
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    // The counter saturates so the timeout level stays up until the next good digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeoutCnt <= '0;
            timeoutReg <= 1'b0;
        end else if (validLatch) begin
            timeoutCnt <= '0;
            timeoutReg <= 1'b0;
        end else if (timeoutCnt != TIMEOUT_MAX) begin
            timeoutCnt <= timeoutCnt + CNT_W'(1);
            if (timeoutFire) begin
                timeoutReg <= 1'b1;
            end
        end
    end

    // A frame publishes the cycle after the mask fills, so it never collides with a latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask          <= '0;
            shadow        <= '0;
            dpSh          <= '0;
            digitReg      <= '0;
            dpReg         <= '0;
            frameValidReg <= 1'b0;
            segErrReg     <= 1'b0;
            anodeErrReg   <= 1'b0;
        end else begin
            frameValidReg <= 1'b0;
            segErrReg     <= segErrEv;
            anodeErrReg   <= anodeErrEv;
            if (mask == 4'hF) begin
                digitReg      <= shadow;
                dpReg         <= dpSh;
                frameValidReg <= 1'b1;
                mask          <= '0;
            end else if (anodeErrEv || timeoutFire) begin
                mask <= '0;
            end else if (validLatch) begin
                shadow[{digitIdx, 2'b00} +: 4] <= nibble;
                dpSh[digitIdx]                 <= dpBit;
                mask[digitIdx]                 <= 1'b1;
            end
        end
    end

    assign bus.digit      = digitReg;
    assign bus.dp         = dpReg;
    assign bus.frameValid = frameValidReg;
    assign bus.segErr     = segErrReg;
    assign bus.anodeErr   = anodeErrReg;
    assign bus.timeout    = timeoutReg;
endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with a short settle window and a short timeout.
// Pulses are counted on the falling edge and compared as deltas around each step.
module tb_seven_segment_capture;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;

    localparam logic [3:0] AN0   = 4'b1110;
    localparam logic [3:0] AN1   = 4'b1101;
    localparam logic [3:0] AN2   = 4'b1011;
    localparam logic [3:0] AN3   = 4'b0111;
    localparam logic [3:0] ANOFF = 4'b1111;
    localparam logic [3:0] ANBAD = 4'b1100;

    localparam logic [6:0] SEG0   = 7'b0000001;
    localparam logic [6:0] SEG1   = 7'b1001111;
    localparam logic [6:0] SEG2   = 7'b0010010;
    localparam logic [6:0] SEG3   = 7'b0000110;
    localparam logic [6:0] SEG4   = 7'b1001100;
    localparam logic [6:0] SEG5   = 7'b0100100;
    localparam logic [6:0] SEG6   = 7'b0100000;
    localparam logic [6:0] SEG7   = 7'b0001111;
    localparam logic [6:0] SEG8   = 7'b0000000;
    localparam logic [6:0] SEG9   = 7'b0000100;
    localparam logic [6:0] SEGA   = 7'b0001000;
    localparam logic [6:0] SEGB   = 7'b1100000;
    localparam logic [6:0] SEGC   = 7'b0110001;
    localparam logic [6:0] SEGD   = 7'b1000010;
    localparam logic [6:0] SEGE   = 7'b0110000;
    localparam logic [6:0] SEGF   = 7'b0111000;
    localparam logic [6:0] SEGBAD = 7'b1111110;
    localparam logic [6:0] SEGOFF = 7'b1111111;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   frameCount = 0;
    int   segErrCount = 0;
    int   anodeErrCount = 0;
    int   lastFrameCyc = 0;
    int   frameBase;
    int   segErrBase;
    int   anodeErrBase;
    int   startCyc;

    seven_segment_capture_if bus ();

    seven_segment_capture #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W         (20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frameValid === 1'b1) begin
            frameCount   <= frameCount + 1;
            lastFrameCyc <= cyc;
        end
        if (bus.segErr === 1'b1) segErrCount <= segErrCount + 1;
        if (bus.anodeErr === 1'b1) anodeErrCount <= anodeErrCount + 1;
    end

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] sg, input logic dpLvl,
                                 input int cycles);
        bus.controlLed = an;
        bus.seg        = sg;
        bus.segDp      = dpLvl;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic markCounts();
        frameBase    = frameCount;
        segErrBase   = segErrCount;
        anodeErrBase = anodeErrCount;
    endtask

    initial begin
        // Reset with random bus activity: everything must read zero.
        rst = 1'b1;
        repeat (3) begin
            bus.controlLed = 4'($urandom);
            bus.seg        = 7'($urandom);
            bus.segDp      = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("reset_digit", 32'(bus.digit), 32'h0);
        checkOutput("reset_dp", 32'(bus.dp), 32'h0);
        checkOutput("reset_frameValid", 32'(bus.frameValid), 32'h0);
        checkOutput("reset_segErr", 32'(bus.segErr), 32'h0);
        checkOutput("reset_anodeErr", 32'(bus.anodeErr), 32'h0);
        checkOutput("reset_timeout", 32'(bus.timeout), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        markCounts();
        applyStimulus(ANOFF, SEGOFF, 1'b1, 20);
        checkOutput("idle_no_frame", 32'(frameCount - frameBase), 32'd0);

        // Normal frame F0A3 with DP only on digit 0, plus exact frame latency.
        markCounts();
        applyStimulus(AN0, SEG3, 1'b1, 20);
        applyStimulus(AN1, SEGA, 1'b0, 20);
        applyStimulus(AN2, SEG0, 1'b0, 20);
        startCyc = cyc;
        applyStimulus(AN3, SEGF, 1'b0, 20);
        checkOutput("normal_frame_count", 32'(frameCount - frameBase), 32'd1);
        checkOutput("normal_digit", 32'(bus.digit), 32'hF0A3);
        checkOutput("normal_dp", 32'(bus.dp), 32'h1);
        checkOutput("normal_latency", 32'(lastFrameCyc - startCyc), 32'(SETTLE + 2));
        checkOutput("normal_no_errors", 32'(segErrCount - segErrBase + anodeErrCount - anodeErrBase), 32'd0);
        applyStimulus(ANOFF, SEGOFF, 1'b1, 20);

        // Three-cycle glitch to an '8' inside digit 0's dwell must not latch.
        markCounts();
        applyStimulus(AN0, SEG5, 1'b0, 10);
        applyStimulus(AN0, SEG8, 1'b0, 3);
        applyStimulus(AN0, SEG5, 1'b0, 3);
        applyStimulus(AN1, SEG6, 1'b0, 20);
        applyStimulus(AN2, SEG7, 1'b0, 20);
        applyStimulus(AN3, SEG9, 1'b0, 20);
        checkOutput("glitch_frame_count", 32'(frameCount - frameBase), 32'd1);
        checkOutput("glitch_digit", 32'(bus.digit), 32'h9765);
        checkOutput("glitch_segErr", 32'(segErrCount - segErrBase), 32'd0);
        checkOutput("glitch_anodeErr", 32'(anodeErrCount - anodeErrBase), 32'd0);
        applyStimulus(ANOFF, SEGOFF, 1'b1, 20);

        // Undecodable digit 1 blocks the frame until a good digit 1 arrives.
        markCounts();
        applyStimulus(AN0, SEGC, 1'b0, 20);
        applyStimulus(AN1, SEGBAD, 1'b0, 20);
        applyStimulus(AN2, SEGD, 1'b0, 20);
        applyStimulus(AN3, SEGE, 1'b0, 20);
        checkOutput("badseg_segErr", 32'(segErrCount - segErrBase), 32'd1);
        checkOutput("badseg_no_frame", 32'(frameCount - frameBase), 32'd0);
        applyStimulus(AN1, SEG1, 1'b0, 20);
        checkOutput("badseg_resend_frame", 32'(frameCount - frameBase), 32'd1);
        checkOutput("badseg_resend_digit", 32'(bus.digit), 32'hED1C);
        applyStimulus(ANOFF, SEGOFF, 1'b1, 20);

        // Bad anode clears the partial mask; all four digits are needed again.
        markCounts();
        applyStimulus(AN0, SEG1, 1'b0, 20);
        applyStimulus(AN1, SEG2, 1'b0, 20);
        applyStimulus(ANBAD, SEG8, 1'b0, 20);
        applyStimulus(AN2, SEG4, 1'b0, 20);
        applyStimulus(AN3, SEGB, 1'b0, 20);
        checkOutput("badanode_anodeErr", 32'(anodeErrCount - anodeErrBase), 32'd1);
        checkOutput("badanode_no_frame", 32'(frameCount - frameBase), 32'd0);
        applyStimulus(AN0, SEG1, 1'b0, 20);
        applyStimulus(AN1, SEG2, 1'b0, 20);
        checkOutput("badanode_frame", 32'(frameCount - frameBase), 32'd1);
        checkOutput("badanode_digit", 32'(bus.digit), 32'hB421);
        applyStimulus(ANOFF, SEGOFF, 1'b1, 20);

        // Timeout: freeze after two digits; it fires 50 cycles after the last latch.
        markCounts();
        applyStimulus(AN0, SEG3, 1'b0, 20);
        applyStimulus(AN1, SEG3, 1'b0, 20);
        waitCycles(30);
        checkOutput("timeout_not_yet", 32'(bus.timeout), 32'h0);
        waitCycles(10);
        checkOutput("timeout_set", 32'(bus.timeout), 32'h1);
        checkOutput("timeout_digit_held", 32'(bus.digit), 32'hB421);
        applyStimulus(AN2, SEG3, 1'b0, 20);
        checkOutput("timeout_cleared", 32'(bus.timeout), 32'h0);
        applyStimulus(AN3, SEG3, 1'b0, 20);
        checkOutput("timeout_mask_cleared", 32'(frameCount - frameBase), 32'd0);

        // Reset mid-frame discards digits 0, 2 and 3 already captured.
        applyStimulus(AN0, SEG3, 1'b0, 20);
        applyStimulus(ANOFF, SEGOFF, 1'b1, 5);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("midreset_digit", 32'(bus.digit), 32'h0);
        checkOutput("midreset_dp", 32'(bus.dp), 32'h0);
        applyStimulus(AN1, SEG3, 1'b0, 20);
        applyStimulus(AN2, SEG3, 1'b0, 20);
        applyStimulus(AN3, SEG3, 1'b0, 20);
        checkOutput("midreset_no_frame", 32'(frameCount - frameBase), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
